// File: rtl/i2s_rx_deserializer.sv
// I2S record-path deserializer: oversamples bclk/reclrc/recdat on mclk, frames signed L/R pairs, queues them in a FIFO.
// Optional I2S_RX_FRAME_CHECK_EN adds a sticky frame_err for short half-frames and a 64-rise half-frame watchdog.
module i2s_rx_deserializer #(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          bclk,
    input  logic                          reclrc,
    input  logic                          recdat,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [SAMPLE_BITS-1:0]        m_left,
    output logic [SAMPLE_BITS-1:0]        m_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [2:0] {SYNC, L_DLY, L_SHIFT, L_PAD, R_DLY, R_SHIFT, R_PAD} state_t;

    logic bclk_s1_q, bclk_s2_q, bclk_s3_q, lr_s1_q, lr_s2_q, dat_s1_q, dat_s2_q;
    logic rise, lr_edge, lr_fall, lr_riseedge, push, pop, push_ok;

    state_t                   state_q, state_d;
    logic [SAMPLE_BITS-1:0]   left_sr_q, left_sr_d, right_sr_q, right_sr_d;
    logic [CW-1:0]            bitcnt_q, bitcnt_d;
    logic                     lr_prev_q, lr_prev_d, bad_q, bad_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     m_valid_q, m_valid_d, overflow_q, overflow_d;
    logic [2*SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];

`ifdef I2S_RX_FRAME_CHECK_EN
    logic       frame_err_q, frame_err_d, short_hf, wdog_trip;
    logic [5:0] halfcnt_q, halfcnt_d;
`endif

    assign rise        = bclk_s2_q & ~bclk_s3_q;
    assign lr_edge     = lr_s2_q ^ lr_prev_q;
    assign lr_fall     = lr_prev_q & ~lr_s2_q;
    assign lr_riseedge = ~lr_prev_q & lr_s2_q;

    // Framing FSM. The rise that reveals the reclrc edge is the I2S one-bit delay slot,
    // so the DLY state's own rise carries the MSB.
    always_comb begin
        state_d    = state_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        bitcnt_d   = bitcnt_q;
        lr_prev_d  = lr_prev_q;
        bad_d      = bad_q;
        push       = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
        halfcnt_d  = halfcnt_q;
        short_hf   = 1'b0;
        wdog_trip  = 1'b0;
`endif
        if (rise) begin
            lr_prev_d = lr_s2_q;
            unique case (state_q)
                SYNC: if (lr_fall) begin
                    state_d = L_DLY;
                    bad_d   = 1'b0;
                end
                L_DLY, L_SHIFT: begin
                    if (lr_edge) begin
                        state_d = R_DLY;
                        bad_d   = 1'b1;
                    end else begin
                        left_sr_d = {left_sr_q[SAMPLE_BITS-2:0], dat_s2_q};
                        if (state_q == L_DLY) begin
                            bitcnt_d = CW'(1);
                            state_d  = L_SHIFT;
                        end else begin
                            bitcnt_d = bitcnt_q + CW'(1);
                            if (bitcnt_q == CW'(SAMPLE_BITS - 1)) state_d = L_PAD;
                        end
                    end
                end
                L_PAD: if (lr_riseedge) state_d = R_DLY;
                R_DLY, R_SHIFT: begin
                    if (lr_edge) begin
                        state_d = L_DLY;
                        bad_d   = 1'b0;
                    end else begin
                        right_sr_d = {right_sr_q[SAMPLE_BITS-2:0], dat_s2_q};
                        if (state_q == R_DLY) begin
                            bitcnt_d = CW'(1);
                            state_d  = R_SHIFT;
                        end else begin
                            bitcnt_d = bitcnt_q + CW'(1);
                            if (bitcnt_q == CW'(SAMPLE_BITS - 1)) state_d = R_PAD;
                        end
                    end
                end
                R_PAD: if (lr_fall) begin
                    push    = ~bad_q;
                    state_d = L_DLY;
                    bad_d   = 1'b0;
                end
                default: state_d = SYNC;
            endcase
`ifdef I2S_RX_FRAME_CHECK_EN
            short_hf  = lr_edge && (state_q inside {L_DLY, L_SHIFT, R_DLY, R_SHIFT});
            wdog_trip = !lr_edge && (state_q != SYNC) && (halfcnt_q == 6'd63);
            halfcnt_d = (lr_edge || state_q == SYNC || wdog_trip) ? 6'd0 : halfcnt_q + 6'd1;
            if (wdog_trip) state_d = SYNC;
`endif
        end
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        pop        = m_valid_q & m_ready;
        push_ok    = push & ((level_q != LW'(FIFO_DEPTH)) | pop);
        overflow_d = overflow_q | (push & ~push_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        m_valid_d  = (level_d != '0);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            {bclk_s1_q, bclk_s2_q, bclk_s3_q} <= 3'b000;
            {lr_s1_q, lr_s2_q, dat_s1_q, dat_s2_q} <= 4'b0000;
            state_q    <= SYNC;
            left_sr_q  <= '0;
            right_sr_q <= '0;
            bitcnt_q   <= '0;
            lr_prev_q  <= 1'b0;
            bad_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            bclk_s1_q  <= bclk;
            bclk_s2_q  <= bclk_s1_q;
            bclk_s3_q  <= bclk_s2_q;
            lr_s1_q    <= reclrc;
            lr_s2_q    <= lr_s1_q;
            dat_s1_q   <= recdat;
            dat_s2_q   <= dat_s1_q;
            state_q    <= state_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            bitcnt_q   <= bitcnt_d;
            lr_prev_q  <= lr_prev_d;
            bad_q      <= bad_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
            if (push_ok) mem_q[wr_ptr_q] <= {left_sr_q, right_sr_q};
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    assign frame_err_d = frame_err_q | short_hf | wdog_trip;

    always_ff @(posedge mclk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            halfcnt_q   <= '0;
        end else begin
            frame_err_q <= frame_err_d;
            halfcnt_q   <= halfcnt_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign m_valid    = m_valid_q;
    assign m_left     = mem_q[rd_ptr_q][2*SAMPLE_BITS-1:SAMPLE_BITS];
    assign m_right    = mem_q[rd_ptr_q][SAMPLE_BITS-1:0];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: 64-bclk I2S frames at bclk = mclk/4, popped pairs logged by a monitor.
module tb_i2s_rx_deserializer;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic FERR_EXP = 1'b1;
`else
    localparam logic FERR_EXP = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rst = 1'b1, bclk = 1'b0, reclrc = 1'b0, recdat = 1'b0, m_ready = 1'b1;
    logic        m_valid, overflow, frame_err;
    logic [15:0] m_left, m_right;
    logic [3:0]  fifo_level;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] ql[$];
    logic [15:0] qr[$];

    i2s_rx_deserializer #(.SAMPLE_BITS(16), .FIFO_DEPTH(8)) dut (
        .mclk(mclk), .rst(rst), .bclk(bclk), .reclrc(reclrc), .recdat(recdat),
        .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
        .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 mclk = ~mclk;

    // Log every accepted pair, sampled mid-cycle.
    always @(negedge mclk) begin
        #1;
        if (m_valid && m_ready && !rst) begin
            ql.push_back(m_left);
            qr.push_back(m_right);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit slot: data/ws change with bclk low, bclk rises halfway.
    task automatic slot(input logic lr, input logic d);
        bclk = 1'b0; reclrc = lr; recdat = d;
        repeat (2) @(negedge mclk);
        bclk = 1'b1;
        repeat (2) @(negedge mclk);
    endtask

    // Slot 0 is the delay bit, slots 1..16 MSB..LSB, the rest padding (driven 1 to expose misalignment).
    task automatic half(input logic lr, input logic [15:0] s, input int nslots, input int first);
        for (int i = first; i < nslots; i++)
            slot(lr, (i >= 1 && i <= 16) ? s[16 - i] : 1'b1);
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int rslots);
        half(1'b0, l, 32, 0);
        half(1'b1, r, rslots, 0);
    endtask

    task automatic tail();
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
        repeat (8) @(negedge mclk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bclk = 1'b0; reclrc = 1'b0; recdat = 1'b0;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        ql.delete();
        qr.delete();
    endtask

    initial begin
        // T1: reset values, then one exact pair (first frame has no preceding 1->0 edge)
        do_reset();
        check("rst_valid", m_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_left", m_left, 0);
        check("rst_right", m_right, 0);
        frame(16'h1234, 16'h5678, 32);
        frame(16'h8001, 16'h7FFE, 32);
        tail();
        check("t1_count", ql.size(), 1);
        check("t1_left", ql[0], 16'h8001);
        check("t1_right", qr[0], 16'h7FFE);
        check("t1_level", fifo_level, 0);

        // T2: stream starts mid right channel
        do_reset();
        half(1'b1, 16'h1111, 32, 10);
        frame(16'h2222, 16'hA333, 32);
        tail();
        check("t2_count", ql.size(), 1);
        check("t2_left", ql[0], 16'h2222);
        check("t2_right", qr[0], 16'hA333);

        // T3: nine pushes into a depth-8 FIFO with no consumer
        do_reset();
        m_ready = 1'b0;
        half(1'b1, 16'h0000, 32, 0);
        for (int k = 0; k < 9; k++) frame(16'h0100 + 16'(k), 16'hF000 + 16'(k), 32);
        tail();
        check("t3_level", fifo_level, 8);
        check("t3_ovf", overflow, 1);
        check("t3_valid", m_valid, 1);
        check("t3_head_l", m_left, 16'h0100);
        check("t3_head_r", m_right, 16'hF000);
        m_ready = 1'b1;
        repeat (12) @(negedge mclk);
        check("t3_count", ql.size(), 8);
        for (int k = 0; k < 8 && k < ql.size(); k++) begin
            check("t3_pop_l", ql[k], 16'h0100 + 16'(k));
            check("t3_pop_r", qr[k], 16'hF000 + 16'(k));
        end
        check("t3_level_end", fifo_level, 0);
        check("t3_valid_end", m_valid, 0);

        // T4: full FIFO, push on the same mclk edge as a pop
        do_reset();
        m_ready = 1'b0;
        half(1'b1, 16'h0000, 32, 0);
        for (int k = 0; k < 8; k++) frame(16'h0200 + 16'(k), 16'h8100 + 16'(k), 32);
        frame(16'h02FF, 16'h81FF, 32);
        bclk = 1'b0; reclrc = 1'b0; recdat = 1'b0;
        repeat (2) @(negedge mclk);
        bclk = 1'b1;
        repeat (2) @(negedge mclk);
        m_ready = 1'b1;
        @(negedge mclk);
        m_ready = 1'b0;
        repeat (8) @(negedge mclk);
        check("t4_ovf", overflow, 0);
        check("t4_level", fifo_level, 8);
        check("t4_one_pop", ql.size(), 1);
        m_ready = 1'b1;
        repeat (12) @(negedge mclk);
        check("t4_count", ql.size(), 9);
        if (ql.size() == 9) begin
            check("t4_first", ql[0], 16'h0200);
            check("t4_second", ql[1], 16'h0201);
            check("t4_tail_l", ql[8], 16'h02FF);
            check("t4_tail_r", qr[8], 16'h81FF);
        end

        // T5: right half cut to 10 bits
        do_reset();
        half(1'b1, 16'h0000, 32, 0);
        frame(16'hC3A5, 16'h5A3C, 32);
        frame(16'hDEAD, 16'hBEEF, 11);
        frame(16'h0F0F, 16'hF0F0, 32);
        tail();
        check("t5_count", ql.size(), 2);
        if (ql.size() == 2) begin
            check("t5_a_l", ql[0], 16'hC3A5);
            check("t5_a_r", qr[0], 16'h5A3C);
            check("t5_b_l", ql[1], 16'h0F0F);
            check("t5_b_r", qr[1], 16'hF0F0);
        end
        check("t5_ferr", frame_err, FERR_EXP);

        // T6: reset during left shifting with two pairs queued
        do_reset();
        m_ready = 1'b0;
        half(1'b1, 16'h0000, 32, 0);
        frame(16'h1111, 16'h2222, 32);
        frame(16'h3333, 16'h4444, 32);
        half(1'b0, 16'h5555, 9, 0);
        repeat (4) @(negedge mclk);
        check("t6_level_pre", fifo_level, 2);
        rst = 1'b1;
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        check("t6_valid", m_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_left", m_left, 0);
        ql.delete();
        qr.delete();
        m_ready = 1'b1;
        half(1'b0, 16'h5555, 32, 9);
        half(1'b1, 16'h6666, 32, 0);
        frame(16'h7777, 16'h8888, 32);
        tail();
        check("t6_count", ql.size(), 1);
        check("t6_l", ql[0], 16'h7777);
        check("t6_r", qr[0], 16'h8888);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
